spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
SPI responder (slave) that receives DATA_W-bit frames from the design's SPI master links (SCLK/SS/MOSI) and returns a DATA_W-bit reply word on MISO in the same frame. It is used for on-board loopback checking of the DAC/Arduino SPI paths and for accepting commands from an external controller. All SPI inputs are asynchronous to clk and are oversampled. Received words are handed to the fabric through a valid/ack handshake.

Parameters:
DATA_W, 16, frame length in bits (MSB first), legal range 8..32
SYNC_STAGES, 2, synchronizer flops on SCLK/SS/MOSI, legal range 2..3

Ports:
clk  input  1  system clock; must be >= 4x SCLK frequency
rst  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0)
ss  input  1  slave select, active-low
mosi  input  1  serial data from master
miso  output  1  serial reply data, MSB first
miso_oe  output  1  high while the frame is selected (synchronized SS low)
tx_data  input  DATA_W  reply word, captured at frame start
tx_taken  output  1  1-cycle pulse when tx_data is captured
rx_data  output  DATA_W  last complete received word
rx_valid  output  1  high from frame completion until rx_ack
rx_ack  input  1  consumer acknowledge; clears rx_valid
overrun  output  1  1-cycle pulse when a word completes while rx_valid is still high
frame_err  output  1  1-cycle pulse when SS deasserts with 0 < bit count < DATA_W
busy  output  1  high in ACTIVE and DONE

Behaviour:
- Reset (rst=0, async):
  - All outputs are 0.
  - rx_data = 0, shift registers = 0, bit counter = 0, state = IDLE.
  - Synchronizer chains reset to sclk=0, ss=1, mosi=0.
- Synchronization and edge detect:
  - SYNC_STAGES flops per input, plus one history flop on sclk and ss for edge detection.
  - An edge is flagged in the cycle after it appears at the synchronizer output.
  - Total input latency is SYNC_STAGES+1 clk.
- State machine:
  - IDLE -> ACTIVE on ss fall.
    - That cycle: tx shift register <= tx_data, tx_taken = 1, bit counter = 0.
    - miso then presents tx_data[DATA_W-1] from the next cycle.
  - ACTIVE, on sclk rise: rx shift register <= {rx_sr[DATA_W-2:0], mosi_sync}; bit counter increments.
  - ACTIVE, on sclk fall: tx shift register shifts left, filling with 0; miso = tx_sr[DATA_W-1].
  - ACTIVE, bit counter reaching DATA_W on a rise:
    - The completed word goes to rx_data in the following cycle.
    - rx_valid = 1; if rx_valid was already 1 and no rx_ack arrives that cycle, overrun pulses and rx_data is overwritten with the new word.
    - State -> DONE.
  - DONE: extra sclk edges are ignored (no rx update, miso = 0); ss rise -> IDLE.
  - ACTIVE, ss rise with 0 < count < DATA_W: frame_err pulses, partial word discarded, rx_data unchanged, -> IDLE.
  - ACTIVE, ss rise with count = 0: no error, -> IDLE.
- Simultaneous events:
  - If ss rise and the final sclk rise are detected in the same cycle, the word completes (rx_valid set) and there is no frame_err.
  - rx_ack in the same cycle as word completion: rx_valid stays 1 with the new word, no overrun.
  - rx_ack while rx_valid = 0: ignored.
- miso is 0 in IDLE; miso_oe = ~ss_sync.
- Async reset mid-frame aborts the frame. After reset release, the block waits in IDLE for the next ss fall, ignoring a low ss that was already present at release (no edge, so no false start).
- Glitch rule: an sclk edge while the block is in IDLE or in the ss-fall cycle is ignored.

Test Plan:
- DATA_W=16, clk=100 MHz, SCLK=1 MHz: master sends 0x38AA while tx_data=0xC49F -> rx_data=0x38AA, rx_valid=1, miso bit stream = 1100010010011111, one tx_taken pulse, no frame_err.
- Two back-to-back frames 0x1234 then 0xABCD with rx_ack never asserted -> overrun pulses once at the second completion, rx_data=0xABCD, rx_valid=1.
- SS released after 9 SCLK cycles of 0xFFFF -> frame_err pulses once, rx_data and rx_valid unchanged, state returns to IDLE (busy=0).
- 18 SCLK cycles in one frame sending 0x8001 then extra 1s -> rx_data=0x8001, the extra edges are ignored, no frame_err on SS rise.
- rx_ack asserted in the exact completion cycle of a second word -> rx_valid remains 1 with the new data, no overrun.
- rst pulsed low after 5 bits, with SS held low through release -> all outputs 0, no frame starts until SS goes high then low again, and the following full frame 0x00FF is received correctly.

Source files
------------

// File: rtl/spi_slave_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_rx_if
//  Purpose  : Bundles the SPI pins and the fabric-side reply/receive
//             handshake of spi_slave_rx. Signal prefixes are written from
//             the responder's point of view (i_ = into the responder).
//  Signals  : i_sclk, i_ss, i_mosi      SPI pins from the master
//             o_miso, o_miso_oe         serial reply and its output enable
//             i_tx_data, o_tx_taken     reply word and capture pulse
//             o_rx_data, o_rx_valid,
//             i_rx_ack                  received word handshake
//             o_overrun, o_frame_err    error pulses
//             o_busy                    frame in progress
//  Revision : 1.0  initial release
// ============================================================================
interface spi_slave_rx_if #(
    parameter int DATA_W = 16
);
    logic              i_sclk;
    logic              i_ss;
    logic              i_mosi;
    logic              o_miso;
    logic              o_miso_oe;
    logic [DATA_W-1:0] i_tx_data;
    logic              o_tx_taken;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_valid;
    logic              i_rx_ack;
    logic              o_overrun;
    logic              o_frame_err;
    logic              o_busy;

    // Responder side (the spi_slave_rx block)
    modport slave (
        input  i_sclk, i_ss, i_mosi, i_tx_data, i_rx_ack,
        output o_miso, o_miso_oe, o_tx_taken, o_rx_data, o_rx_valid,
               o_overrun, o_frame_err, o_busy
    );

    // SPI master / fabric consumer side
    modport master (
        output i_sclk, i_ss, i_mosi, i_tx_data, i_rx_ack,
        input  o_miso, o_miso_oe, o_tx_taken, o_rx_data, o_rx_valid,
               o_overrun, o_frame_err, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_rx
//  Purpose  : SPI mode-0 responder. Oversamples SCLK/SS/MOSI on clk,
//             receives DATA_W-bit MSB-first frames and shifts a reply word
//             out on MISO in the same frame. Completed words are offered
//             through a valid/ack handshake.
//  Ports    : clk    system clock (>= 4x SCLK)
//             rst_n  asynchronous active-low reset
//             bus    spi_slave_rx_if.slave (SPI pins + fabric handshake)
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    spi_slave_rx_if.slave bus
);
    localparam int         c_CNT_W   = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_ACTIVE = 2'd1;
    localparam logic [1:0] c_S_DONE   = 2'd2;

    // ---------------- input synchronizers and edge detection ----------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_hist;
    logic                   r_ss_hist;
    logic                   r_sclk_rise;
    logic                   r_sclk_fall;
    logic                   r_ss_rise;
    logic                   r_ss_fall;
    // Fills with ones after reset release; once full the chains hold real
    // pin values rather than their reset pattern.
    logic [SYNC_STAGES:0]   r_flush;
    // Set only after SS has been seen high with valid chains, so a SS that
    // is already low when reset releases can never start a frame.
    logic                   r_armed;

    logic w_sclk_s;
    logic w_ss_s;
    logic w_mosi_s;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_hist <= 1'b0;
            r_ss_hist   <= 1'b1;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_ss_rise   <= 1'b0;
            r_ss_fall   <= 1'b0;
            r_flush     <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.i_sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0],   bus.i_ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
            r_sclk_hist <= w_sclk_s;
            r_ss_hist   <= w_ss_s;
            // Edge flags are registered: they assert the cycle after the
            // edge shows at the synchronizer output.
            r_sclk_rise <= w_sclk_s & ~r_sclk_hist;
            r_sclk_fall <= ~w_sclk_s & r_sclk_hist;
            r_ss_rise   <= w_ss_s & ~r_ss_hist;
            r_ss_fall   <= ~w_ss_s & r_ss_hist;
            r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
            r_armed     <= r_armed | (r_flush[SYNC_STAGES] & w_ss_s);
        end
    end

    // ---------------- frame state machine ----------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [DATA_W-1:0]  r_rx_sr;
    logic [DATA_W-1:0]  r_tx_sr;
    logic [DATA_W-1:0]  r_rx_data;
    logic               r_rx_valid;
    logic               r_complete;

    logic w_start;
    logic w_last;

    assign w_start = r_ss_fall & r_armed;
    // Final rising edge of the frame; takes priority over a coincident SS rise.
    assign w_last  = (r_state == c_S_ACTIVE) & r_sclk_rise & (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_start) w_state_nxt = c_S_ACTIVE;
            end
            c_S_ACTIVE: begin
                if (w_last)         w_state_nxt = c_S_DONE;
                else if (r_ss_rise) w_state_nxt = c_S_IDLE;
            end
            c_S_DONE: begin
                if (r_ss_rise) w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    logic w_tx_taken;
    logic w_frame_err;
    logic w_overrun;
    logic w_miso;
    logic w_busy;

    always_comb begin
        w_tx_taken  = 1'b0;
        w_frame_err = 1'b0;
        w_miso      = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_tx_taken = w_start;
            end
            c_S_ACTIVE: begin
                w_busy      = 1'b1;
                w_miso      = r_tx_sr[DATA_W-1];
                // A partial frame counts bits already taken plus any rise
                // arriving together with the SS release.
                w_frame_err = r_ss_rise & ~w_last & ((r_cnt != '0) | r_sclk_rise);
            end
            c_S_DONE: begin
                w_busy = 1'b1;
            end
            default: ;
        endcase
        w_overrun = r_complete & r_rx_valid & ~bus.i_rx_ack;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_complete <= 1'b0;
        end else begin
            if (r_state == c_S_IDLE) begin
                if (w_start) begin
                    r_tx_sr <= bus.i_tx_data;
                    r_rx_sr <= '0;
                    r_cnt   <= '0;
                end
            end else if (r_state == c_S_ACTIVE) begin
                if (r_sclk_rise) begin
                    r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_mosi_s};
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                end
                if (r_sclk_fall) begin
                    r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                end
            end

            r_complete <= w_last;

            // Completion outranks a coincident ack so the new word stays valid.
            if (r_complete) begin
                r_rx_data  <= r_rx_sr;
                r_rx_valid <= 1'b1;
            end else if (bus.i_rx_ack) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.o_miso      = w_miso;
    assign bus.o_miso_oe   = ~w_ss_s;
    assign bus.o_tx_taken  = w_tx_taken;
    assign bus.o_rx_data   = r_rx_data;
    assign bus.o_rx_valid  = r_rx_valid;
    assign bus.o_overrun   = w_overrun;
    assign bus.o_frame_err = w_frame_err;
    assign bus.o_busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_rx
//  Purpose  : Self-checking bench for spi_slave_rx (DATA_W=16, 2 sync
//             stages). Directed frame table, hand-written reset sequence,
//             then random frames scored against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_rx;
    localparam int DW   = 16;
    localparam int HALF = 8;   // clk cycles per SCLK half period

    logic clk;
    logic rst_n;

    spi_slave_rx_if #(.DATA_W(DW)) bus ();

    spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters, sampled on the falling clock edge
    int c_taken = 0;
    int c_ovr   = 0;
    int c_ferr  = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_tx_taken)  c_taken++;
            if (bus.o_overrun)   c_ovr++;
            if (bus.o_frame_err) c_ferr++;
        end
    end

    // Frame-level reference state
    logic [DW-1:0] m_data;
    bit            m_valid;

    typedef struct {
        logic [DW-1:0] mosi_w;
        int            nbits;
        logic [DW-1:0] tx_w;
        bit            pre_ack;
        bit            ack_done;
        logic [DW-1:0] exp_data;
        bit            exp_valid;
        int            exp_ovr;
        int            exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one SPI frame of nbits SCLK cycles (bits past DW are 1s) and
    // counts MISO bits differing from the reply word (0 after DW bits).
    task automatic do_frame(input logic [DW-1:0] w, input int nbits,
                            input logic [DW-1:0] tx, input bit ack_done,
                            output int miso_bad);
        logic exp_b;
        miso_bad      = 0;
        bus.i_tx_data = tx;
        bus.i_ss      = 1'b0;
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            bus.i_mosi = (i < DW) ? w[DW-1-i] : 1'b1;
            tick(HALF);
            exp_b = (i < DW) ? tx[DW-1-i] : 1'b0;
            if (bus.o_miso !== exp_b) miso_bad++;
            bus.i_sclk = 1'b1;
            if (ack_done && i == DW-1) begin
                // Word lands four clocks after the last SCLK rise is applied
                tick(4);
                bus.i_rx_ack = 1'b1;
                tick(1);
                bus.i_rx_ack = 1'b0;
                tick(HALF-5);
            end else begin
                tick(HALF);
            end
            bus.i_sclk = 1'b0;
        end
        tick(HALF);
        bus.i_ss   = 1'b1;
        bus.i_mosi = 1'b0;
        tick(2*HALF);
    endtask

    task automatic run_frame(input string tag, input logic [DW-1:0] w, input int nbits,
                             input logic [DW-1:0] tx, input bit pre_ack, input bit ack_done,
                             input logic [DW-1:0] exp_data, input bit exp_valid,
                             input int exp_ovr, input int exp_ferr);
        int b_taken, b_ovr, b_ferr, bad;
        if (pre_ack) begin
            bus.i_rx_ack = 1'b1;
            tick(1);
            bus.i_rx_ack = 1'b0;
            tick(1);
        end
        b_taken = c_taken; b_ovr = c_ovr; b_ferr = c_ferr;
        do_frame(w, nbits, tx, ack_done, bad);
        check({tag, " rx_data"},   32'(bus.o_rx_data), 32'(exp_data));
        check({tag, " rx_valid"},  32'(bus.o_rx_valid), 32'(exp_valid));
        check({tag, " overrun"},   32'(c_ovr - b_ovr), 32'(exp_ovr));
        check({tag, " frame_err"}, 32'(c_ferr - b_ferr), 32'(exp_ferr));
        check({tag, " tx_taken"},  32'(c_taken - b_taken), 32'd1);
        check({tag, " miso_bits"}, 32'(bad), 32'd0);
        check({tag, " busy"},      32'(bus.o_busy), 32'd0);
    endtask

    // Frame-level model: a frame of at least DW bits delivers the first DW
    // bits; a shorter non-empty frame is an error and leaves state alone.
    task automatic model_frame(input logic [DW-1:0] w, input int nbits,
                               input bit pre_ack, input bit ack_done,
                               output int exp_ovr, output int exp_ferr);
        exp_ovr  = 0;
        exp_ferr = 0;
        if (pre_ack) m_valid = 1'b0;
        if (nbits >= DW) begin
            exp_ovr = (m_valid && !ack_done) ? 1 : 0;
            m_data  = w;
            m_valid = 1'b1;
        end else if (nbits > 0) begin
            exp_ferr = 1;
        end
    endtask

    initial begin
        int b_taken, sel, nb, eo, ef;
        logic [DW-1:0] rw, rt;
        bit pa, ad;

        vecs[0] = '{16'h38AA, 16, 16'hC49F, 1'b0, 1'b0, 16'h38AA, 1'b1, 0, 0};
        vecs[1] = '{16'h1234, 16, 16'h5A5A, 1'b1, 1'b0, 16'h1234, 1'b1, 0, 0};
        vecs[2] = '{16'hABCD, 16, 16'h0001, 1'b0, 1'b0, 16'hABCD, 1'b1, 1, 0};
        vecs[3] = '{16'hFFFF,  9, 16'h8000, 1'b0, 1'b0, 16'hABCD, 1'b1, 0, 1};
        vecs[4] = '{16'h8001, 18, 16'hFFFF, 1'b1, 1'b0, 16'h8001, 1'b1, 0, 0};
        vecs[5] = '{16'h0F0F, 16, 16'h3C3C, 1'b0, 1'b1, 16'h0F0F, 1'b1, 0, 0};
        vecs[6] = '{16'h0000,  0, 16'h1111, 1'b1, 1'b0, 16'h0F0F, 1'b0, 0, 0};

        rst_n         = 1'b0;
        bus.i_sclk    = 1'b0;
        bus.i_ss      = 1'b1;
        bus.i_mosi    = 1'b0;
        bus.i_tx_data = '0;
        bus.i_rx_ack  = 1'b0;
        tick(4);
        check("reset rx_data",  32'(bus.o_rx_data), 32'd0);
        check("reset outputs",  32'({bus.o_miso, bus.o_miso_oe, bus.o_tx_taken, bus.o_rx_valid,
                                     bus.o_overrun, bus.o_frame_err, bus.o_busy}), 32'd0);
        rst_n = 1'b1;
        tick(10);

        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].mosi_w, vecs[i].nbits, vecs[i].tx_w,
                      vecs[i].pre_ack, vecs[i].ack_done, vecs[i].exp_data,
                      vecs[i].exp_valid, vecs[i].exp_ovr, vecs[i].exp_ferr);
        end

        // Reset in the middle of a frame with SS held low through release
        bus.i_tx_data = 16'hFFFF;
        bus.i_ss      = 1'b0;
        tick(HALF);
        for (int i = 0; i < 5; i++) begin
            bus.i_mosi = 1'b1;
            tick(HALF);
            bus.i_sclk = 1'b1;
            tick(HALF);
            bus.i_sclk = 1'b0;
        end
        check("midrst busy before", 32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        #2;
        check("midrst rx_data", 32'(bus.o_rx_data), 32'd0);
        check("midrst outputs", 32'({bus.o_miso, bus.o_miso_oe, bus.o_tx_taken, bus.o_rx_valid,
                                     bus.o_overrun, bus.o_frame_err, bus.o_busy}), 32'd0);
        tick(3);
        rst_n   = 1'b1;
        b_taken = c_taken;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            bus.i_sclk = 1'b1;
            tick(HALF);
            bus.i_sclk = 1'b0;
            tick(HALF);
        end
        check("postrst no start", 32'(c_taken - b_taken), 32'd0);
        check("postrst busy",     32'(bus.o_busy), 32'd0);
        check("postrst rx_valid", 32'(bus.o_rx_valid), 32'd0);
        bus.i_mosi = 1'b0;
        bus.i_ss   = 1'b1;
        tick(2*HALF);
        run_frame("postrst frame", 16'h00FF, 16, 16'h5AA5, 1'b0, 1'b0, 16'h00FF, 1'b1, 0, 0);

        // Random frames against the model
        m_data  = 16'h00FF;
        m_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      nb = 0;
            else if (sel <= 3) nb = $urandom_range(1, DW-1);
            else if (sel <= 7) nb = DW;
            else               nb = $urandom_range(DW+1, DW+2);
            rw = DW'($urandom);
            rt = DW'($urandom);
            pa = ($urandom_range(0, 1) == 1);
            ad = (nb >= DW) && ($urandom_range(0, 2) == 0);
            model_frame(rw, nb, pa, ad, eo, ef);
            run_frame($sformatf("rnd%0d", k), rw, nb, rt, pa, ad, m_data, m_valid, eo, ef);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
